// File: rtl/regs_wb_queue.sv
// Write-back queue for the Regs register file: merges ALU and load results into a
// small FIFO, drains one register write per cycle and forwards pending results.
module regs_wb_queue #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 5,
  parameter  int DW    = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          m_valid,
  output logic          m_ready,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_data,
  output logic [AW-1:0] reg_W_addr,
  output logic [DW-1:0] wdata,
  output logic          reg_we,
  input  logic [AW-1:0] fwd_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic [CW-1:0] count
);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW-1:0] free_s;
  logic          a_push_s, m_push_s, pop_s;
  logic [PW-1:0] m_slot_s;
  logic [PW-1:0] fwd_idx_s;

  // Ready is derived from the registered occupancy only; A keeps priority on the last slot.
  always_comb begin
    free_s  = CW'(DEPTH) - count_q;
    a_ready = 1'b0;
    m_ready = 1'b0;
    if (rst) begin
      a_ready = (free_s >= CW'(1));
      m_ready = (free_s >= CW'(2)) || ((free_s == CW'(1)) && !a_valid);
    end else begin
      a_ready = 1'b0;
      m_ready = 1'b0;
    end
  end

  // Push/pop decisions and next-state pointers; address-0 results are dropped after the handshake.
  always_comb begin
    a_push_s = a_valid && a_ready && (a_addr != {AW{1'b0}});
    m_push_s = m_valid && m_ready && (m_addr != {AW{1'b0}});
    pop_s    = (count_q != {CW{1'b0}});
    if (a_push_s) begin
      m_slot_s = tail_q + PW'(1);
    end else begin
      m_slot_s = tail_q;
    end
    tail_d  = tail_q + PW'(a_push_s) + PW'(m_push_s);
    head_d  = head_q + PW'(pop_s);
    count_d = count_q + CW'(a_push_s) + CW'(m_push_s) - CW'(pop_s);
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {AW{1'b0}};
        data_q[i] <= {DW{1'b0}};
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (a_push_s) begin
        addr_q[tail_q] <= a_addr;
        data_q[tail_q] <= a_data;
      end
      if (m_push_s) begin
        addr_q[m_slot_s] <= m_addr;
        data_q[m_slot_s] <= m_data;
      end
    end
  end

  // Write port presents the head entry whenever the queue is non-empty.
  always_comb begin
    reg_we = (count_q != {CW{1'b0}});
    count  = count_q;
    if (reg_we) begin
      reg_W_addr = addr_q[head_q];
      wdata      = data_q[head_q];
    end else begin
      reg_W_addr = {AW{1'b0}};
      wdata      = {DW{1'b0}};
    end
  end

  // Scan oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = {DW{1'b0}};
    fwd_idx_s = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s = head_q + PW'(i);
      if ((CW'(i) < count_q) && (fwd_addr != {AW{1'b0}}) && (addr_q[fwd_idx_s] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx_s];
      end else begin
        fwd_hit  = fwd_hit;
        fwd_data = fwd_data;
      end
    end
  end

endmodule

// File: tb/tb_regs_wb_queue.sv
// Scoreboard bench for regs_wb_queue: a queue-based reference model predicts
// ready/count/forwarding, and a monitor checks every write against expected order.
module tb_regs_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          a_valid = 1'b0, m_valid = 1'b0;
  logic          a_ready, m_ready;
  logic [AW-1:0] a_addr = '0, m_addr = '0, fwd_addr = '0;
  logic [DW-1:0] a_data = '0, m_data = '0;
  logic [AW-1:0] reg_W_addr;
  logic [DW-1:0] wdata, fwd_data;
  logic          reg_we, fwd_hit;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;
  ent_t mq[$];
  ent_t exp_wr[$];
  int max_count = 0;

  regs_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .reg_W_addr(reg_W_addr), .wdata(wdata), .reg_we(reg_we),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write must be the oldest outstanding accepted entry.
  ent_t e;
  always @(negedge clk) begin
    if (rst) begin
      if (reg_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %h expected no write", reg_W_addr, wdata);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(reg_W_addr), 32'(e.a));
          chk("wr_data", wdata, e.d);
        end
        chk("wr_nonzero_addr", 32'(reg_W_addr != '0), 32'd1);
      end else begin
        chk("idle_addr", 32'(reg_W_addr), 32'd0);
        chk("idle_data", wdata, 32'd0);
      end
    end
  end

  // One clock cycle: drive at +2 after posedge, check combinational outputs, update model at the edge.
  task automatic step(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                      input logic [AW-1:0] fa);
    int free;
    bit er_a, er_m, hit;
    logic [DW-1:0] fd;
    a_valid = av; a_addr = aa; a_data = ad;
    m_valid = mv; m_addr = ma; m_data = md;
    fwd_addr = fa;
    #1;
    free = DEPTH - mq.size();
    er_a = (free >= 1);
    er_m = (free >= 2) || (free == 1 && !av);
    hit = 1'b0;
    fd  = '0;
    if (fa != '0) begin
      foreach (mq[k]) begin
        if (mq[k].a == fa) begin
          hit = 1'b1;
          fd  = mq[k].d;
        end
      end
    end
    chk("a_ready", 32'(a_ready), 32'(er_a));
    chk("m_ready", 32'(m_ready), 32'(er_m));
    chk("count", 32'(count), 32'(mq.size()));
    chk("reg_we", 32'(reg_we), 32'(mq.size() != 0));
    chk("fwd_hit", 32'(fwd_hit), 32'(hit));
    chk("fwd_data", fwd_data, fd);
    @(posedge clk);
    if (mq.size() > 0) void'(mq.pop_front());
    if (av && er_a && aa != '0) begin
      mq.push_back({aa, ad});
      exp_wr.push_back({aa, ad});
    end
    if (mv && er_m && ma != '0) begin
      mq.push_back({ma, md});
      exp_wr.push_back({ma, md});
    end
    if (mq.size() > max_count) max_count = mq.size();
    #2;
  endtask

  task automatic idle(input logic [AW-1:0] fa);
    step(1'b0, '0, '0, 1'b0, '0, '0, fa);
  endtask

  initial begin
    // Reset values while rst is held low.
    fwd_addr = 5'd5;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    idle(5'd0);
    idle(5'd7);

    // Three pending entries discarded by a mid-operation reset.
    step(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h202, 5'd0);
    step(1'b1, 5'd3, 32'h303, 1'b1, 5'd4, 32'h404, 5'd0);
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_reg_we", 32'(reg_we), 32'd0);
    chk("midrst_a_ready", 32'(a_ready), 32'd0);
    mq.delete();
    exp_wr.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    idle(5'd3);

    // Single ALU push; written one cycle later.
    step(1'b1, 5'd5, 32'h11, 1'b0, '0, '0, 5'd5);
    idle(5'd5);
    idle(5'd5);

    // Same destination from both ports: youngest (M) forwards, writes stay in order.
    step(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 5'd3);
    idle(5'd3);
    idle(5'd3);
    idle(5'd3);

    // Fill to 3, then contend for the last slot.
    step(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77, 5'd6);
    step(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99, 5'd7);
    step(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 5'd11);
    step(1'b0, '0, '0, 1'b1, 5'd12, 32'hCC, 5'd10);
    repeat (5) idle(5'd12);

    // Address-0 push is accepted but dropped.
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, 5'd0);
    idle(5'd0);

    // Alternating stream x1..x10 against continuous drain.
    for (int i = 1; i <= 10; i++) begin
      if (i % 2 == 1) step(1'b1, 5'(i), 32'h1000 + 32'(i), 1'b0, '0, '0, 5'(i));
      else            step(1'b0, '0, '0, 1'b1, 5'(i), 32'h2000 + 32'(i), 5'(i - 1));
    end
    repeat (3) idle(5'd10);

    // Randomized traffic with a narrow address range so forwarding hits often.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)));
    end
    repeat (6) idle(5'd0);

    chk("drained", 32'(exp_wr.size()), 32'd0);
    chk("max_count_bound", 32'(max_count <= DEPTH), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regs_wb_queue.md
Name: regs_wb_queue

Overview:
Write-back initiator for the Regs register file. It takes results from two producers, the ALU path (A) and the load path (M), through valid/ready handshakes. It buffers them in a DEPTH-entry FIFO and drives Regs' single write port (reg_W_addr, wdata, reg_we) with one write per cycle. It also gives the decode stage a forwarding lookup over pending, not-yet-written results.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset; asynchronous, active-low (0 = reset)
a_valid  in  1  ALU result valid
a_ready  out  1  queue can accept ALU result
a_addr  in  AW  ALU destination register
a_data  in  DW  ALU result
m_valid  in  1  load result valid
m_ready  out  1  queue can accept load result
m_addr  in  AW  load destination register
m_data  in  DW  load result
reg_W_addr  out  AW  write address to Regs
wdata  out  DW  write data to Regs
reg_we  out  1  write enable to Regs
fwd_addr  in  AW  forwarding lookup address
fwd_hit  out  1  a pending entry matches fwd_addr
fwd_data  out  DW  data of youngest matching entry
count  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, async):
  - all entries invalid; head/tail pointers 0; count 0.
  - reg_we=0, reg_W_addr=0, wdata=0, fwd_hit=0, fwd_data=0.
  - a_ready=m_ready=0 while rst=0.
  - Reset mid-operation discards every pending entry; no write is issued.
- Ready rules (combinational from registered count only; a same-cycle pop is not credited):
  - free = DEPTH - count.
  - a_ready = (free >= 1).
  - m_ready = (free >= 2) or (free == 1 and not a_valid).
  - The A port wins the last slot.
- Accept: a transfer occurs when valid && ready at posedge.
  - A transfer with addr==0 completes the handshake but is discarded: not enqueued, no slot used.
- Ordering: if both A and M transfer in the same cycle, A is enqueued at tail and M at tail+1. A is treated as older.
- Drain:
  - reg_we = (count != 0); reg_W_addr/wdata = head entry, combinational.
  - reg_W_addr=0 and wdata=0 when empty.
  - Head pops at every posedge while count != 0. Regs captures on that same edge.
  - Latency: an entry accepted at edge N appears on the write port in cycle N+1 if the queue was empty, and is written into Regs at edge N+1.
- Count update: count_next = count + pushes(0..2) - pop(0/1). Simultaneous push and pop on a full queue is legal; the pop frees space only for the next cycle.
- Pointers wrap modulo DEPTH.
- Forwarding (combinational):
  - compares fwd_addr against all valid entries; the youngest match (closest to tail) wins.
  - Entries being pushed this cycle are not visible; the head entry being popped this cycle is visible.
  - fwd_addr==0 gives fwd_hit=0, fwd_data=0. No match gives fwd_hit=0, fwd_data=0.
- Never: two writes per cycle; writes to register 0; reordering of accepted entries.

Test Plan:
1. Reset low, then high; idle -> reg_we=0, count=0, a_ready=m_ready=1. Pulse rst low with 3 entries pending -> count=0 and reg_we=0 immediately, with no writes to Regs.
2. A pushes (5, 0x11) at edge 1 into an empty queue -> cycle 2: reg_we=1, reg_W_addr=5, wdata=0x11. After edge 2: Regs x5=0x11, count=0.
3. A pushes (3, 0xA) and M pushes (3, 0xB) in the same cycle -> writes x3=0xA then x3=0xB on consecutive cycles. Before the first write, fwd_addr=3 gives fwd_hit=1, fwd_data=0xB.
4. Queue holds 3 entries (DEPTH=4) and both ports are valid -> a_ready=1, m_ready=0; only A enqueues. The next cycle (count=3 after the simultaneous pop) gives m_ready=1.
5. A pushes addr 0 with data 0xFFFF -> handshake completes, count unchanged, no reg_we; fwd_addr=0 gives fwd_hit=0.
6. Stream 10 alternating A/M pushes with addresses 1..10 against continuous drain -> Regs receives x1..x10 in order with correct data. Count never exceeds DEPTH; pointers wrap without loss.
